rotor_btof_pipe: RTL and testbench
==================================

Name: rotor_btof_pipe

Overview:
- Return (back-to-front) path of the Enigma scrambler: takes the reflector output and passes it through inverse rotor2, then inverse rotor1, then inverse rotor0. Inverses the front-to-back chain rotor0 -> rotor1 -> rotor2.
- Three-stage registered pipeline with valid/ready handshakes on both sides. Rotor positions are captured together with each character and travel with it, so rotor stepping between characters never corrupts an in-flight character.

Parameters:
- SYMS, 26, alphabet size; legal symbol and position values are 0..SYMS-1 (SYMS <= 64).
- W, 6, symbol/position width.

Ports:
- clk       input   1   system clock
- rst       input   1   synchronous, active-high reset
- in_valid  input   1   in_data and positions are valid
- in_ready  output  1   block accepts a character this cycle
- in_data   input   W   reflector output symbol
- r0_position input W   rotor0 offset for this character
- r1_position input W   rotor1 offset for this character
- r2_position input W   rotor2 offset for this character
- out_valid output  1   out_data is valid
- out_ready input   1   downstream accepts out_data
- out_data  output  W   scrambled symbol, before the plugboard
- out_err   output  1   character carried an out-of-range symbol or position

Behaviour:
- Reset: synchronous on rst=1 at a clk edge. All stage valid bits are cleared and in-flight characters are discarded. out_valid=0, out_data=0, out_err=0. in_ready=0 while rst=1.
- Stage k output: out = (INV_Rk[(in + p) mod SYMS] - p + SYMS) mod SYMS. Use W+1-bit intermediates and a single conditional subtract of SYMS; no divider.
- Stage order and positions:
  - S1 = inverse rotor2 using r2_position.
  - S2 = inverse rotor1 using r1_position.
  - S3 = inverse rotor0 using r0_position.
  - r1_position and r0_position are registered alongside the data through S1 and S2.
- Handshake:
  - Transfer on in_valid&in_ready, or on out_valid&out_ready.
  - advance = !out_valid | out_ready; in_ready = advance & !rst.
  - When advance=1, all stages shift together; a bubble shifts as valid=0.
  - When advance=0, every stage holds. out_data and out_valid stay stable until accepted.
- Latency: 3 cycles from acceptance to out_valid with no backpressure. Throughput is 1 character per cycle.
- Out-of-range handling: if in_data or any position >= SYMS, the err bit is set at S1 and carried down the pipe. The data then bypasses all stages unchanged, and out_err=1 with that character only.
- Wrap-around: in+p up to 2*SYMS-2 wraps once. A subtraction result below 0 wraps by +SYMS.
- Simultaneous events:
  - A new accept and an output pop in the same cycle both complete.
  - rst has priority over any handshake.
- Positions sampled while in_valid=0 are ignored.

Decomposition:
- Package enigma_pkg holds:
  - SYMS default;
  - forward tables R0_FWD, R1_FWD, R2_FWD, shared with the front-to-back path;
  - inverse tables R0_INV, R1_INV, R2_INV, as constant functions derived from the forward tables;
  - a mod_add/mod_sub helper.
- One sub-module, rotor_inv_stage, parameterized by ROTOR_ID. It contains the combinational inverse lookup plus an output register with valid/err/hold enable. It is instantiated 3 times.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_err=0; nothing emerges afterwards.
- Round trip:
  - Sweep in_data 0..25 with positions (0,0,0), then (5,17,25).
  - Feed out_data into the front-to-back chain with the same positions -> it returns the original symbol for all 52 cases.
  - Latency is exactly 3 cycles and out_err=0.
- Wrap boundary: in_data=25, positions (25,25,25) -> out_data equals the golden model (indices 50 -> 24), out_err=0.
- Backpressure:
  - Stream 5 characters back-to-back with out_ready=0 on cycles 4-7 -> in_ready drops on cycles 4-7.
  - No character is lost or duplicated, order is preserved, and out_data is stable while stalled.
- Per-character positions: change r2_position every cycle (0,1,2,3) with in_data=4 constant -> each output matches the model for its own sampled position.
- Error and mid-stream reset:
  - in_data=30 -> out_data=30 with out_err=1 on that beat only.
  - Pulse rst while 3 characters are in flight -> all are dropped and out_valid=0 on the next cycle.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared Enigma constants: rotor wirings, inverse lookups and modular helpers
// used by both the front-to-back and the back-to-front scrambler paths.
package enigma_pkg;

  localparam int SYMS_DEF = 26;
  localparam int W_DEF    = 6;

  typedef logic [W_DEF-1:0] sym_t;
  typedef logic [W_DEF:0]   wide_t;

  // Historic rotors I, II, III as forward wirings
  localparam int R0_FWD [26] = '{4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9};
  localparam int R1_FWD [26] = '{0,9,3,10,18,8,17,20,23,1,11,7,22,19,12,2,16,6,25,13,15,24,5,21,14,4};
  localparam int R2_FWD [26] = '{1,3,5,7,9,11,2,15,17,19,23,21,25,13,24,4,10,12,8,22,6,0,16,20,18,14};

  function automatic sym_t rotor_fwd(input int id, input sym_t idx);
    sym_t r;
    r = '0;
    for (int i = 0; i < SYMS_DEF; i++) begin
      if (sym_t'(i) == idx) begin
        case (id)
          0:       r = sym_t'(R0_FWD[i]);
          1:       r = sym_t'(R1_FWD[i]);
          default: r = sym_t'(R2_FWD[i]);
        endcase
      end
    end
    return r;
  endfunction

  // Inverse wiring found by matching the forward table; folds to a constant mux
  function automatic sym_t rotor_inv(input int id, input sym_t x);
    sym_t r;
    r = '0;
    for (int i = 0; i < SYMS_DEF; i++)
      if (rotor_fwd(id, sym_t'(i)) == x) r = sym_t'(i);
    return r;
  endfunction

  function automatic sym_t R0_INV(input sym_t x); return rotor_inv(0, x); endfunction
  function automatic sym_t R1_INV(input sym_t x); return rotor_inv(1, x); endfunction
  function automatic sym_t R2_INV(input sym_t x); return rotor_inv(2, x); endfunction

  // Operands are < m, so one conditional subtract suffices
  function automatic wide_t mod_add(input wide_t a, input wide_t b, input wide_t m);
    wide_t s;
    s = a + b;
    if (s >= m) s = s - m;
    return s;
  endfunction

  function automatic wide_t mod_sub(input wide_t a, input wide_t b, input wide_t m);
    wide_t s;
    s = a + m - b;
    if (s >= m) s = s - m;
    return s;
  endfunction

endpackage

// File: rtl/rotor_inv_stage.sv
// One inverse-rotor step: offset, inverse lookup, un-offset, then a holdable
// output register carrying valid and error flags.
module rotor_inv_stage
  import enigma_pkg::*;
#(
  parameter int ROTOR_ID = 0,
  parameter int SYMS     = 26,
  parameter int W        = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  input  logic         in_err,
  input  logic [W-1:0] in_data,
  input  logic [W-1:0] pos,
  output logic         valid,
  output logic         err,
  output logic [W-1:0] data
);

  localparam logic [W:0] SYMS_W = (W+1)'(SYMS);

  logic [W:0]   idx, back;
  logic [W-1:0] look, res;

  always_comb begin
    idx  = mod_add({1'b0, in_data}, {1'b0, pos}, SYMS_W);
    look = rotor_inv(ROTOR_ID, idx[W-1:0]);
    back = mod_sub({1'b0, look}, {1'b0, pos}, SYMS_W);
    // Bad characters pass through untouched so the error is traceable downstream
    res  = in_err ? in_data : back[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      err   <= 1'b0;
      data  <= '0;
    end else if (en) begin
      valid <= in_valid;
      err   <= in_valid & in_err;
      data  <= res;
    end
  end

endmodule

// File: rtl/rotor_btof_pipe.sv
// Back-to-front scrambler path: inverse rotor2 -> rotor1 -> rotor0 as a
// three-stage pipeline; positions ride along with each character.
module rotor_btof_pipe
  import enigma_pkg::*;
#(
  parameter int SYMS = SYMS_DEF,
  parameter int W    = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [W-1:0] r0_position,
  input  logic [W-1:0] r1_position,
  input  logic [W-1:0] r2_position,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err
);

  localparam int         STAGES = 3;
  localparam logic [W:0] SYMS_W = (W+1)'(SYMS);

  logic                          advance;
  logic [STAGES:0]               vld_pipe, err_pipe;
  logic [STAGES:0][W-1:0]        data_pipe;
  logic [STAGES-1:0][W-1:0]      stg_pos;
  logic [W-1:0]                  r1_q, r0_q, r0_qq;

  // Whole pipe moves as one; a stall freezes every stage
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance & !rst;

  assign vld_pipe[0]  = in_valid;
  assign data_pipe[0] = in_data;
  assign err_pipe[0]  = ({1'b0, in_data}     >= SYMS_W) | ({1'b0, r0_position} >= SYMS_W) |
                        ({1'b0, r1_position} >= SYMS_W) | ({1'b0, r2_position} >= SYMS_W);

  assign stg_pos[0] = r2_position;
  assign stg_pos[1] = r1_q;
  assign stg_pos[2] = r0_qq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_q  <= '0;
      r0_q  <= '0;
      r0_qq <= '0;
    end else if (advance) begin
      r1_q  <= r1_position;
      r0_q  <= r0_position;
      r0_qq <= r0_q;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    rotor_inv_stage #(
      .ROTOR_ID (STAGES-1-k),
      .SYMS     (SYMS),
      .W        (W)
    ) u_stg (
      .clk      (clk),
      .rst      (rst),
      .en       (advance),
      .in_valid (vld_pipe[k]),
      .in_err   (err_pipe[k]),
      .in_data  (data_pipe[k]),
      .pos      (stg_pos[k]),
      .valid    (vld_pipe[k+1]),
      .err      (err_pipe[k+1]),
      .data     (data_pipe[k+1])
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_err   = err_pipe[STAGES];
  assign out_data  = data_pipe[STAGES];

endmodule

// File: tb/tb_rotor_btof_pipe.sv
// Directed bench for rotor_btof_pipe: scoreboard with inverse model plus
// forward-chain round trip, latency, stall and reset checks.
module tb_rotor_btof_pipe;

  localparam int SYMS = 26;
  localparam int W    = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] r0_position = '0, r1_position = '0, r2_position = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_err;

  always #5 clk = ~clk;

  rotor_btof_pipe #(.SYMS(SYMS), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .r0_position (r0_position),
    .r1_position (r1_position),
    .r2_position (r2_position),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_err     (out_err)
  );

  localparam int RF [3][26] = '{
    '{4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9},
    '{0,9,3,10,18,8,17,20,23,1,11,7,22,19,12,2,16,6,25,13,15,24,5,21,14,4},
    '{1,3,5,7,9,11,2,15,17,19,23,21,25,13,24,4,10,12,8,22,6,0,16,20,18,14}};

  typedef struct { int d; int p0; int p1; int p2; int c; } ent_t;
  ent_t q[$];
  ent_t e;

  int n_chk = 0, n_bad = 0, cyc = 0;
  bit lat_chk = 1'b1;
  bit hold_v = 1'b0;
  logic [W-1:0] hold_d;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fwd_stage(input int id, input int x, input int p);
    return (RF[id][(x + p) % SYMS] - p + SYMS) % SYMS;
  endfunction

  function automatic int inv_stage(input int id, input int x, input int p);
    int idx, v;
    idx = (x + p) % SYMS;
    v = 0;
    for (int i = 0; i < SYMS; i++) if (RF[id][i] == idx) v = i;
    return (v - p + SYMS) % SYMS;
  endfunction

  function automatic bit is_bad(input ent_t t);
    return (t.d >= SYMS) || (t.p0 >= SYMS) || (t.p1 >= SYMS) || (t.p2 >= SYMS);
  endfunction

  function automatic int model(input ent_t t);
    if (is_bad(t)) return t.d;
    return inv_stage(0, inv_stage(1, inv_stage(2, t.d, t.p2), t.p1), t.p0);
  endfunction

  function automatic int fwd_chain(input int x, input int p0, input int p1, input int p2);
    return fwd_stage(2, fwd_stage(1, fwd_stage(0, x, p0), p1), p2);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop on output transfer, push on input transfer
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(hold_d));
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious", 1, 0);
        else begin
          e = q.pop_front();
          chk("data", int'(out_data), model(e));
          chk("err", int'(out_err), is_bad(e) ? 1 : 0);
          if (!is_bad(e)) chk("round_trip", fwd_chain(int'(out_data), e.p0, e.p1, e.p2), e.d);
          if (lat_chk) chk("latency", cyc - e.c, 3);
        end
      end
      if (in_valid && in_ready)
        q.push_back('{int'(in_data), int'(r0_position), int'(r1_position), int'(r2_position), cyc});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Leaves in_valid high so consecutive calls stream back-to-back
  task automatic send(input int d, input int p0, input int p1, input int p2);
    int n;
    in_valid = 1'b1;
    in_data = W'(d); r0_position = W'(p0); r1_position = W'(p1); r2_position = W'(p2);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin chk("send_timeout", 0, 1); break; end
    end
    tick();
  endtask

  initial begin
    bit fire;
    int k, n;
    // reset with in_valid held high
    in_valid = 1'b1; in_data = W'(3);
    repeat (2) begin
      tick();
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_err", int'(out_err), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    idle(6);

    for (int d = 0; d < SYMS; d++) send(d, 0, 0, 0);
    idle(6);
    for (int d = 0; d < SYMS; d++) send(d, 5, 17, 25);
    idle(6);

    // wrap boundary: hand-derived result is 15
    send(25, 25, 25, 25);
    in_valid = 1'b0;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 10) begin chk("wrap_timeout", 0, 1); break; end
    end
    chk("wrap", int'(out_data), 15);
    idle(5);

    for (int i = 0; i < 4; i++) send(4, 0, 0, i);
    idle(6);

    // backpressure: out_ready low on cycles 4..7 of a 5-char stream
    lat_chk = 1'b0;
    k = 0;
    for (int c = 0; c < 16; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      if (k < 5) begin
        in_valid = 1'b1;
        in_data = W'(10 + k); r0_position = W'(1); r1_position = W'(2); r2_position = W'(3);
      end else in_valid = 1'b0;
      @(negedge clk);
      if (c >= 4 && c <= 7) chk("bp_in_ready", int'(in_ready), 0);
      fire = in_valid && in_ready;
      tick();
      if (fire) k++;
    end
    chk("bp_sent", k, 5);
    out_ready = 1'b1;
    idle(8);
    lat_chk = 1'b1;

    // error bypass, surrounded by clean characters
    send(7, 0, 0, 0);
    send(30, 0, 0, 0);
    send(8, 0, 0, 0);
    send(3, 0, 40, 0);
    idle(6);

    // mid-stream reset drops everything in flight
    send(1, 2, 3, 4);
    send(2, 2, 3, 4);
    send(3, 2, 3, 4);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_flush_valid", int'(out_valid), 0);
    idle(8);

    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
